seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with a frame-synchronous overlay source,
// per-digit blink and leading-zero blanking. All outputs are registered.
module seg_scan_ctrl #(
   parameter int SCAN_DIV     = 50000,
   parameter int BLINK_FRAMES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] bcd_main,
   input  logic [15:0] bcd_ovl,
   input  logic        ovl_req,
   input  logic [7:0]  ovl_len,
   input  logic [3:0]  blink_en,
   input  logic        lz_suppress,
   output logic        ovl_ack,
   output logic        ovl_busy,
   output logic        frame_tick,
   output logic [3:0]  DIGIT,
   output logic [6:0]  DISPLAY
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
   localparam logic [7:0]    BLINK_MAX = 8'(BLINK_FRAMES - 1);

   typedef enum logic [1:0] {D0 = 2'd0, D1 = 2'd1, D2 = 2'd2, D3 = 2'd3} scan_e;
   typedef enum logic {IDLE = 1'b0, OVL = 1'b1} src_e;

   scan_e         scan_q, scan_d;
   src_e          src_q, src_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [15:0]   main_q, main_d, ovl_q, ovl_d;
   logic [7:0]    len_q, len_d, bcnt_q, bcnt_d;
   logic          phase_q, phase_d;
   logic [3:0]    dig_q, dig_d;
   logic [6:0]    seg_q, seg_d;
   logic          ack_q, ack_d, busy_q, busy_d, ft_q, ft_d;

   logic          slot_tick_s, wrap_s, accept_s, blank_s;
   logic [3:0]    nib_s, anode_s, lzb_s;

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      case (v)
         4'd0:    seg_decode = 7'b1000000;
         4'd1:    seg_decode = 7'b1111001;
         4'd2:    seg_decode = 7'b0100100;
         4'd3:    seg_decode = 7'b0110000;
         4'd4:    seg_decode = 7'b0011001;
         4'd5:    seg_decode = 7'b0010010;
         4'd6:    seg_decode = 7'b0000010;
         4'd7:    seg_decode = 7'b1111000;
         4'd8:    seg_decode = 7'b0000000;
         4'd9:    seg_decode = 7'b0010000;
         default: seg_decode = 7'b1111111;
      endcase
   endfunction

   assign slot_tick_s = (presc_q == PRESC_MAX);
   assign wrap_s      = slot_tick_s && (scan_q == D3);
   assign accept_s    = wrap_s && (src_q == IDLE) && ovl_req;

   // State registers; scan_q names the digit driven at the next slot, so D0 after reset
   // behaves as if digit3 had just been shown.
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_q <= D0;
         src_q  <= IDLE;
      end else begin
         scan_q <= scan_d;
         src_q  <= src_d;
      end
   end

   // Scan and source next-state logic.
   always_comb begin
      scan_d = scan_q;
      src_d  = src_q;
      case (scan_q)
         D0:      scan_d = slot_tick_s ? D1 : D0;
         D1:      scan_d = slot_tick_s ? D2 : D1;
         D2:      scan_d = slot_tick_s ? D3 : D2;
         D3:      scan_d = slot_tick_s ? D0 : D3;
         default: scan_d = D0;
      endcase
      case (src_q)
         IDLE: begin
            if (accept_s) src_d = OVL;
            else          src_d = IDLE;
         end
         OVL: begin
            if (wrap_s && (len_q <= 8'd1)) src_d = IDLE;
            else                           src_d = OVL;
         end
         default: src_d = IDLE;
      endcase
   end

   // Datapath next values: prescaler, frame-aligned shadows, overlay length, blink phase.
   always_comb begin
      presc_d = slot_tick_s ? '0 : presc_q + PW'(1);
      main_d  = wrap_s ? bcd_main : main_q;
      ovl_d   = accept_s ? bcd_ovl : ovl_q;
      len_d   = len_q;
      bcnt_d  = bcnt_q;
      phase_d = phase_q;
      if (accept_s) begin
         len_d = (ovl_len == 8'd0) ? 8'd1 : ovl_len;
      end else if (wrap_s && (src_q == OVL)) begin
         len_d = len_q - 8'd1;
      end else begin
         len_d = len_q;
      end
      if (wrap_s) begin
         if (bcnt_q >= BLINK_MAX) begin
            bcnt_d  = 8'd0;
            phase_d = ~phase_q;
         end else begin
            bcnt_d  = bcnt_q + 8'd1;
         end
      end else begin
         bcnt_d = bcnt_q;
      end
   end

   // Output decode: digit select, blanking and next values of the registered outputs.
   always_comb begin
      lzb_s[3] = (main_q[15:12] == 4'd0);
      lzb_s[2] = lzb_s[3] && (main_q[11:8] == 4'd0);
      lzb_s[1] = lzb_s[2] && (main_q[7:4] == 4'd0);
      lzb_s[0] = 1'b0;
      nib_s    = 4'd0;
      anode_s  = 4'b1111;
      blank_s  = 1'b0;
      case (scan_q)
         D0: begin
            nib_s   = (src_q == OVL) ? ovl_q[3:0] : main_q[3:0];
            anode_s = 4'b1110;
            blank_s = (lz_suppress && lzb_s[0]) || (phase_q && blink_en[0]);
         end
         D1: begin
            nib_s   = (src_q == OVL) ? ovl_q[7:4] : main_q[7:4];
            anode_s = 4'b1101;
            blank_s = (lz_suppress && lzb_s[1]) || (phase_q && blink_en[1]);
         end
         D2: begin
            nib_s   = (src_q == OVL) ? ovl_q[11:8] : main_q[11:8];
            anode_s = 4'b1011;
            blank_s = (lz_suppress && lzb_s[2]) || (phase_q && blink_en[2]);
         end
         D3: begin
            nib_s   = (src_q == OVL) ? ovl_q[15:12] : main_q[15:12];
            anode_s = 4'b0111;
            blank_s = (lz_suppress && lzb_s[3]) || (phase_q && blink_en[3]);
         end
         default: begin
            nib_s   = 4'd0;
            anode_s = 4'b1111;
            blank_s = 1'b1;
         end
      endcase
      if (slot_tick_s) begin
         dig_d = anode_s;
         seg_d = (blank_s && (src_q == IDLE)) ? 7'b1111111 : seg_decode(nib_s);
      end else begin
         dig_d = dig_q;
         seg_d = seg_q;
      end
      ack_d  = accept_s;
      busy_d = (src_q == OVL);
      ft_d   = wrap_s;
   end

   // Datapath and output registers; the main shadow tracks bcd_main throughout reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
         main_q  <= bcd_main;
         ovl_q   <= 16'd0;
         len_q   <= 8'd0;
         bcnt_q  <= 8'd0;
         phase_q <= 1'b0;
         dig_q   <= 4'b1111;
         seg_q   <= 7'b1111111;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         ft_q    <= 1'b0;
      end else begin
         presc_q <= presc_d;
         main_q  <= main_d;
         ovl_q   <= ovl_d;
         len_q   <= len_d;
         bcnt_q  <= bcnt_d;
         phase_q <= phase_d;
         dig_q   <= dig_d;
         seg_q   <= seg_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         ft_q    <= ft_d;
      end
   end

   assign DIGIT      = dig_q;
   assign DISPLAY    = seg_q;
   assign ovl_ack    = ack_q;
   assign ovl_busy   = busy_q;
   assign frame_tick = ft_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed scoreboard bench for seg_scan_ctrl with SCAN_DIV=4, BLINK_FRAMES=2.
module tb_seg_scan_ctrl;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                          S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                          S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                          BL = 7'b1111111;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] bcd_main = 16'd0, bcd_ovl = 16'd0;
   logic        ovl_req = 1'b0;
   logic [7:0]  ovl_len = 8'd0;
   logic [3:0]  blink_en = 4'd0;
   logic        lz_suppress = 1'b0;
   logic        ovl_ack, ovl_busy, frame_tick;
   logic [3:0]  DIGIT;
   logic [6:0]  DISPLAY;

   typedef struct packed {
      logic [3:0] dig;
      logic [6:0] seg;
      logic       ft;
      logic       ack;
      logic       busy0;
      logic       busy_rest;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   failures = 0;

   seg_scan_ctrl #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
      .clk(clk), .rst(rst), .bcd_main(bcd_main), .bcd_ovl(bcd_ovl),
      .ovl_req(ovl_req), .ovl_len(ovl_len), .blink_en(blink_en),
      .lz_suppress(lz_suppress), .ovl_ack(ovl_ack), .ovl_busy(ovl_busy),
      .frame_tick(frame_tick), .DIGIT(DIGIT), .DISPLAY(DISPLAY)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_slot(input logic [3:0] dig, input logic [6:0] seg, input logic ft,
                            input logic ack, input logic b0, input logic br);
      exp_t e;
      e.dig = dig; e.seg = seg; e.ft = ft; e.ack = ack; e.busy0 = b0; e.busy_rest = br;
      sb_q.push_back(e);
   endtask

   // One displayed frame: digit0..digit3; ack/busy transitions happen in the digit3 slot.
   task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                             input logic [6:0] s3, input logic ack, input logic bin,
                             input logic bout);
      push_slot(4'b1110, s0, 1'b0, 1'b0, bin, bin);
      push_slot(4'b1101, s1, 1'b0, 1'b0, bin, bin);
      push_slot(4'b1011, s2, 1'b0, 1'b0, bin, bin);
      push_slot(4'b0111, s3, 1'b1, ack, bin, bout);
   endtask

   task automatic run_slots(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL sb_empty observed=0 expected=1");
            e = '0;
         end else begin
            e = sb_q.pop_front();
         end
         for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("DIGIT", 8'(DIGIT), 8'(e.dig));
            chk("DISPLAY", 8'(DISPLAY), 8'(e.seg));
            chk("frame_tick", 8'(frame_tick), (c == 0) ? 8'(e.ft) : 8'd0);
            chk("ovl_ack", 8'(ovl_ack), (c == 0) ? 8'(e.ack) : 8'd0);
            chk("ovl_busy", 8'(ovl_busy), (c == 0) ? 8'(e.busy0) : 8'(e.busy_rest));
         end
      end
   endtask

   // Entered at a negedge; leaves the DUT 3 cycles before the first slot update.
   task automatic do_reset();
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk);
         @(negedge clk);
         chk("rst_DIGIT", 8'(DIGIT), 8'hF);
         chk("rst_DISPLAY", 8'(DISPLAY), 8'h7F);
         chk("rst_flags", 8'({ovl_ack, ovl_busy, frame_tick}), 8'd0);
      end
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         @(negedge clk);
         chk("pre_DIGIT", 8'(DIGIT), 8'hF);
         chk("pre_DISPLAY", 8'(DISPLAY), 8'h7F);
         chk("pre_flags", 8'({ovl_ack, ovl_busy, frame_tick}), 8'd0);
      end
   endtask

   initial begin
      bcd_main = 16'h1234;
      do_reset();
      push_frame(S4, S3, S2, S1, 1'b0, 1'b0, 1'b0);
      run_slots(4);
      // A mid-frame change must not disturb the frame in progress.
      push_frame(S4, S3, S2, S1, 1'b0, 1'b0, 1'b0);
      run_slots(2);
      bcd_main = 16'h5678;
      run_slots(2);
      lz_suppress = 1'b1;
      bcd_main = 16'h0070;
      push_frame(S8, S7, S6, S5, 1'b0, 1'b0, 1'b0);
      run_slots(4);
      push_frame(S0, S7, BL, BL, 1'b0, 1'b0, 1'b0);
      run_slots(4);
      lz_suppress = 1'b0;
      bcd_main = 16'h0000;
      push_frame(S0, S7, S0, S0, 1'b0, 1'b0, 1'b0);
      run_slots(4);
      lz_suppress = 1'b1;
      bcd_main = 16'h0102;
      push_frame(S0, BL, BL, BL, 1'b0, 1'b0, 1'b0);
      run_slots(4);
      // Overlay requested mid-frame, accepted only at the frame end.
      push_frame(S2, S0, S1, BL, 1'b1, 1'b0, 1'b1);
      run_slots(2);
      ovl_req = 1'b1;
      ovl_len = 8'd2;
      bcd_ovl = 16'hAAA5;
      run_slots(2);
      ovl_req = 1'b0;
      push_frame(S5, BL, BL, BL, 1'b0, 1'b1, 1'b1);
      run_slots(4);
      push_frame(S5, BL, BL, BL, 1'b0, 1'b1, 1'b0);
      run_slots(4);
      // Zero length means one frame; a held request is re-acked one frame after exit.
      ovl_req = 1'b1;
      ovl_len = 8'd0;
      bcd_ovl = 16'h0003;
      push_frame(S2, S0, S1, BL, 1'b1, 1'b0, 1'b1);
      run_slots(4);
      push_frame(S3, S0, S0, S0, 1'b0, 1'b1, 1'b0);
      run_slots(4);
      push_frame(S2, S0, S1, BL, 1'b1, 1'b0, 1'b1);
      run_slots(4);
      ovl_req = 1'b0;
      push_frame(S3, S0, S0, S0, 1'b0, 1'b1, 1'b0);
      run_slots(4);
      push_frame(S2, S0, S1, BL, 1'b0, 1'b0, 1'b0);
      run_slots(4);
      // Blink: digit0 on for two frames, off for two.
      bcd_main = 16'h0008;
      blink_en = 4'b0001;
      lz_suppress = 1'b0;
      do_reset();
      push_frame(S8, S0, S0, S0, 1'b0, 1'b0, 1'b0);
      run_slots(4);
      push_frame(S8, S0, S0, S0, 1'b0, 1'b0, 1'b0);
      run_slots(4);
      push_frame(BL, S0, S0, S0, 1'b0, 1'b0, 1'b0);
      run_slots(4);
      push_frame(BL, S0, S0, S0, 1'b0, 1'b0, 1'b0);
      run_slots(4);
      push_frame(S8, S0, S0, S0, 1'b0, 1'b0, 1'b0);
      run_slots(4);
      ovl_req = 1'b1;
      ovl_len = 8'd5;
      bcd_ovl = 16'h1111;
      push_frame(S8, S0, S0, S0, 1'b1, 1'b0, 1'b1);
      run_slots(4);
      ovl_req = 1'b0;
      push_frame(S1, S1, S1, S1, 1'b0, 1'b1, 1'b1);
      run_slots(4);
      push_slot(4'b1110, S1, 1'b0, 1'b0, 1'b1, 1'b1);
      push_slot(4'b1101, S1, 1'b0, 1'b0, 1'b1, 1'b1);
      run_slots(2);
      // Reset in the middle of an overlay; no ack may follow without a new request.
      do_reset();
      push_frame(S8, S0, S0, S0, 1'b0, 1'b0, 1'b0);
      run_slots(4);
      push_frame(S8, S0, S0, S0, 1'b0, 1'b0, 1'b0);
      run_slots(4);
      chk("sb_drained", 8'(sb_q.size()), 8'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
